// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and constants for the PLL lock supervisor: state encoding,
// counter widths and the parameter range check used at elaboration.
package pll_lock_supervisor_pkg;

    localparam int CNT_W   = 20;
    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_PWRDN     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } sup_state_e;

    // Every timing parameter must be representable by the shared phase counter.
    function automatic logic param_in_range(input int value);
        return (value >= 1) && (value <= (1 << CNT_W));
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL power-down, lock acquisition and stabilisation, and holds the
// PLL-clocked fabric in reset until the lock has been stable long enough.
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int PD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               pll_lock,
    input  logic               restart,
    output logic               pll_powerdown_n,
    output logic               fabric_reset_n,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  loss_cnt,
    output logic [STATE_W-1:0] state
);

    if (!param_in_range(PD_CYCLES) || !param_in_range(LOCK_TIMEOUT) ||
        !param_in_range(STABLE_CYCLES) || !param_in_range(MAX_RETRIES)) begin : g_bad_param
        $error("pll_lock_supervisor: every parameter must lie in 1..2**20");
    end

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] PD_LAST      = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock counts as the first stable cycle.
    localparam logic [CNT_W-1:0] STABLE_LAST  =
        CNT_W'((STABLE_CYCLES >= 2) ? (STABLE_CYCLES - 2) : 0);
    localparam logic [CNT_W:0]   RETRY_ONE    = (CNT_W + 1)'(1);
    localparam logic [CNT_W:0]   RETRY_MAX    = (CNT_W + 1)'(MAX_RETRIES);
    localparam logic [CNT_W:0]   RETRY_SHOWN  = (CNT_W + 1)'((1 << RETRY_W) - 1);
    localparam logic [LOSS_W-1:0] LOSS_ONE    = LOSS_W'(1);

    logic lock_s;

    sup_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W:0]     retry_q, retry_d;
    logic [RETRY_W-1:0] retry_out_q, retry_out_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic               pd_n_q, pd_n_d;
    logic               fab_q, fab_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (resetn),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        retry_d = retry_q;
        loss_d  = loss_q;

        if (restart) begin
            state_d = ST_PWRDN;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_PWRDN: begin
                    if (cnt_q == PD_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = (STABLE_CYCLES == 1) ? ST_RUN : ST_STABILIZE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q == RETRY_MAX) begin
                            state_d = ST_FAULT;
                        end else begin
                            retry_d = retry_q + RETRY_ONE;
                            state_d = ST_PWRDN;
                        end
                    end
                end
                ST_STABILIZE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_PWRDN;
                        if (loss_q != '1) begin
                            loss_d = loss_q + LOSS_ONE;
                        end
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_PWRDN;
                end
            endcase
        end

        // A restart re-enters PWRDN, so it restarts the phase like any state change.
        if (restart || (state_d != state_q)) begin
            cnt_d = '0;
        end
        if (state_d == ST_RUN) begin
            retry_d = '0;
        end

        pd_n_d      = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABILIZE) ||
                      (state_d == ST_RUN);
        fab_d       = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);
        fault_d     = (state_d == ST_FAULT);
        retry_out_d = (retry_d > RETRY_SHOWN) ? '1 : retry_d[RETRY_W-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_PWRDN;
            cnt_q       <= '0;
            retry_q     <= '0;
            retry_out_q <= '0;
            loss_q      <= '0;
            pd_n_q      <= 1'b0;
            fab_q       <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            retry_out_q <= retry_out_d;
            loss_q      <= loss_d;
            pd_n_q      <= pd_n_d;
            fab_q       <= fab_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_powerdown_n = pd_n_q;
    assign fabric_reset_n  = fab_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign retry_cnt       = retry_out_q;
    assign loss_cnt        = loss_q;
    assign state           = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: a phase-level model is checked against
// the DUT on every falling edge, alongside hand-computed milestone values.
module tb_pll_lock_supervisor;
    import pll_lock_supervisor_pkg::*;

    localparam int PD = 4;
    localparam int TO = 100;
    localparam int ST = 8;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pllLock = 1'b0;
    logic       restart = 1'b0;
    logic       pllPowerdownN;
    logic       fabricResetN;
    logic       ready;
    logic       fault;
    logic [3:0] retryCnt;
    logic [7:0] lossCnt;
    logic [2:0] state;

    int testsRun = 0;
    int testsFailed = 0;

    pll_lock_supervisor #(
        .PD_CYCLES     (PD),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (ST),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .pll_lock        (pllLock),
        .restart         (restart),
        .pll_powerdown_n (pllPowerdownN),
        .fabric_reset_n  (fabricResetN),
        .ready           (ready),
        .fault           (fault),
        .retry_cnt       (retryCnt),
        .loss_cnt        (lossCnt),
        .state           (state)
    );

    always #5 clk = ~clk;

    // Model phases: powered down, searching (waiting or stabilising), up, dead.
    typedef enum logic [1:0] {M_OFF = 2'd0, M_SEARCH = 2'd1, M_UP = 2'd2, M_DEAD = 2'd3} mphase_e;

    typedef struct packed {
        mphase_e phase;
        int      cycles;
        int      run;
        int      retry;
        int      loss;
        bit      hist0;
        bit      hist1;
    } model_t;

    localparam model_t MODEL_RESET = '{phase: M_OFF, cycles: 0, run: 0, retry: 0,
                                       loss: 0, hist0: 1'b0, hist1: 1'b0};

    model_t mdl = MODEL_RESET;

    function automatic model_t modelNext(input model_t cur, input bit lockIn, input bit restartIn);
        model_t nxt;
        bit     lockSeen;
        nxt = cur;
        lockSeen = cur.hist1;
        nxt.hist1 = cur.hist0;
        nxt.hist0 = lockIn;
        if (restartIn) begin
            nxt.phase = M_OFF;
            nxt.cycles = 0;
            nxt.run = 0;
            nxt.retry = 0;
        end else begin
            case (cur.phase)
                M_OFF: begin
                    nxt.cycles = cur.cycles + 1;
                    if (nxt.cycles == PD) begin
                        nxt.phase = M_SEARCH;
                        nxt.cycles = 0;
                        nxt.run = 0;
                    end
                end
                M_SEARCH: begin
                    if (lockSeen) begin
                        nxt.run = cur.run + 1;
                        if (nxt.run == ST) begin
                            nxt.phase = M_UP;
                            nxt.run = 0;
                            nxt.retry = 0;
                        end
                    end else if (cur.run > 0) begin
                        nxt.run = 0;
                        nxt.cycles = 0;
                    end else begin
                        nxt.cycles = cur.cycles + 1;
                        if (nxt.cycles == TO) begin
                            nxt.cycles = 0;
                            if (cur.retry == MR) begin
                                nxt.phase = M_DEAD;
                            end else begin
                                nxt.retry = cur.retry + 1;
                                nxt.phase = M_OFF;
                            end
                        end
                    end
                end
                M_UP: begin
                    if (!lockSeen) begin
                        nxt.phase = M_OFF;
                        nxt.cycles = 0;
                        if (cur.loss < 255) nxt.loss = cur.loss + 1;
                    end
                end
                default: begin
                end
            endcase
        end
        return nxt;
    endfunction

    function automatic int expState(input model_t m);
        case (m.phase)
            M_OFF:    return int'(ST_PWRDN);
            M_SEARCH: return (m.run > 0) ? int'(ST_STABILIZE) : int'(ST_WAIT_LOCK);
            M_UP:     return int'(ST_RUN);
            default:  return int'(ST_FAULT);
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit lockVal, input bit restartVal, input int cycles);
        pllLock = lockVal;
        restart = restartVal;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic relock();
        applyStimulus(1'b0, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 4);
        applyStimulus(1'b1, 1'b0, 10);
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) mdl <= MODEL_RESET;
        else         mdl <= modelNext(mdl, pllLock, restart);
    end

    always @(negedge clk) begin
        checkOutput("model pd_n", int'(pllPowerdownN),
                    (mdl.phase == M_SEARCH || mdl.phase == M_UP) ? 1 : 0);
        checkOutput("model fabric_reset_n", int'(fabricResetN), (mdl.phase == M_UP) ? 1 : 0);
        checkOutput("model ready", int'(ready), (mdl.phase == M_UP) ? 1 : 0);
        checkOutput("model fault", int'(fault), (mdl.phase == M_DEAD) ? 1 : 0);
        checkOutput("model retry_cnt", int'(retryCnt), (mdl.retry > 15) ? 15 : mdl.retry);
        checkOutput("model loss_cnt", int'(lossCnt), mdl.loss);
        checkOutput("model state", int'(state), expState(mdl));
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset pd_n", int'(pllPowerdownN), 0);
        checkOutput("reset fabric_reset_n", int'(fabricResetN), 0);
        checkOutput("reset ready", int'(ready), 0);
        checkOutput("reset fault", int'(fault), 0);
        checkOutput("reset retry", int'(retryCnt), 0);
        checkOutput("reset loss", int'(lossCnt), 0);
        checkOutput("reset state", int'(state), 0);

        resetn = 1'b1;
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("nominal pd_n after 3", int'(pllPowerdownN), 0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("nominal pd_n after 4", int'(pllPowerdownN), 1);
        checkOutput("nominal state wait", int'(state), 1);
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b0, 9);
        checkOutput("nominal ready at lock+9", int'(ready), 0);
        checkOutput("nominal state stabilize", int'(state), 2);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("nominal ready at lock+10", int'(ready), 1);
        checkOutput("nominal fabric at lock+10", int'(fabricResetN), 1);
        checkOutput("nominal state run", int'(state), 3);
        applyStimulus(1'b1, 1'b0, 3);

        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("loss fabric within 3", int'(fabricResetN), 0);
        checkOutput("loss count 1", int'(lossCnt), 1);
        checkOutput("loss state pwrdn", int'(state), 0);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("loss relock pd_n", int'(pllPowerdownN), 1);
        applyStimulus(1'b1, 1'b0, 10);
        checkOutput("loss relock ready", int'(ready), 1);

        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("glitch prep loss 2", int'(lossCnt), 2);
        applyStimulus(1'b0, 1'b0, 104);
        checkOutput("glitch prep timeout state", int'(state), 0);
        checkOutput("glitch prep retry 1", int'(retryCnt), 1);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("glitch prep wait", int'(state), 1);
        applyStimulus(1'b1, 1'b0, 5);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 2);
        checkOutput("glitch back to wait", int'(state), 1);
        checkOutput("glitch ready low", int'(ready), 0);
        checkOutput("glitch retry kept", int'(retryCnt), 1);
        applyStimulus(1'b1, 1'b0, 7);
        checkOutput("glitch resync +9 ready", int'(ready), 0);
        checkOutput("glitch resync +9 state", int'(state), 2);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("glitch resync +10 ready", int'(ready), 1);
        checkOutput("glitch run retry cleared", int'(retryCnt), 0);

        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("restart+loss state", int'(state), 0);
        checkOutput("restart+loss retry", int'(retryCnt), 0);
        checkOutput("restart+loss loss kept", int'(lossCnt), 2);
        checkOutput("restart+loss ready", int'(ready), 0);
        applyStimulus(1'b0, 1'b0, 104);
        checkOutput("nolock attempt1 end", int'(state), 0);
        checkOutput("nolock retry 1", int'(retryCnt), 1);
        applyStimulus(1'b0, 1'b0, 207);
        checkOutput("nolock last wait", int'(state), 1);
        checkOutput("nolock retry 2", int'(retryCnt), 2);
        checkOutput("nolock fault not yet", int'(fault), 0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("nolock fault", int'(fault), 1);
        checkOutput("nolock pd_n", int'(pllPowerdownN), 0);
        checkOutput("nolock retry final", int'(retryCnt), 2);
        checkOutput("nolock state", int'(state), 4);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("fault sticky", int'(fault), 1);

        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("restart fault state", int'(state), 0);
        checkOutput("restart fault cleared", int'(fault), 0);
        checkOutput("restart fault retry", int'(retryCnt), 0);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("restart pd_n", int'(pllPowerdownN), 1);

        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("midreset in stabilize", int'(state), 2);
        #1 resetn = 1'b0;
        #1;
        checkOutput("midreset pd_n", int'(pllPowerdownN), 0);
        checkOutput("midreset fabric", int'(fabricResetN), 0);
        checkOutput("midreset ready", int'(ready), 0);
        checkOutput("midreset loss", int'(lossCnt), 0);
        checkOutput("midreset state", int'(state), 0);
        applyStimulus(1'b1, 1'b0, 2);
        resetn = 1'b1;
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("rerelease pd_n after 3", int'(pllPowerdownN), 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("rerelease pd_n after 4", int'(pllPowerdownN), 1);
        applyStimulus(1'b1, 1'b0, 7);
        checkOutput("rerelease ready early", int'(ready), 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("rerelease ready", int'(ready), 1);

        for (int i = 0; i < 300; i++) begin
            relock();
            if (i == 254) checkOutput("saturate loss 255", int'(lossCnt), 255);
        end
        checkOutput("saturate loss held", int'(lossCnt), 255);
        checkOutput("saturate ready", int'(ready), 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter PD_CYCLES, default 16: number of cycles PLL_POWERDOWN_N is held low per power-down phase.
REQ-002 Parameter LOCK_TIMEOUT, default 65535: number of cycles allowed for lock per attempt.
REQ-003 Parameter STABLE_CYCLES, default 1024: number of consecutive locked cycles required before release.
REQ-004 Parameter MAX_RETRIES, default 3: number of re-attempts after the first timeout before fault.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 CLK  in  1  free-running reference clock (the PLL REF_CLK, never a PLL output).
REQ-007 RESETN  in  1  asynchronous active-low reset.
REQ-008 PLL_LOCK  in  1  PLL LOCK output, asynchronous to CLK.
REQ-009 RESTART  in  1  single-cycle request to force a full relock sequence.
REQ-010 PLL_POWERDOWN_N  out  1  drives the PLL POWERDOWN_N input.
REQ-011 FABRIC_RESET_N  out  1  active-low reset for logic clocked by the PLL output.
REQ-012 READY  out  1  high only in RUN.
REQ-013 FAULT  out  1  high only in FAULT.
REQ-014 RETRY_CNT  out  4  retries consumed in the current sequence.
REQ-015 LOSS_CNT  out  8  count of lock losses in RUN, saturating at 255.
REQ-016 STATE  out  3  current state encoding, for debug.

Function
REQ-017 PLL_LOCK SHALL pass through a 2-flop synchronizer (lock_s); that adds 2 cycles of latency.
REQ-018 The FSM states SHALL be PWRDN, WAIT_LOCK, STABILIZE, RUN and FAULT, using a single 20-bit phase counter that clears on every state change.
REQ-019 PWRDN: PLL_POWERDOWN_N=0; after PD_CYCLES cycles, the FSM goes to WAIT_LOCK.
REQ-020 WAIT_LOCK: PLL_POWERDOWN_N=1.
- lock_s=1 goes to STABILIZE.
- Otherwise, after LOCK_TIMEOUT cycles: if RETRY_CNT=MAX_RETRIES, go to FAULT; else RETRY_CNT+1 and go to PWRDN.
REQ-021 STABILIZE: lock_s=1 for STABLE_CYCLES consecutive cycles goes to RUN; any lock_s=0 cycle returns to WAIT_LOCK with a fresh timeout and no retry increment.
REQ-022 RUN: FABRIC_RESET_N=1, READY=1, RETRY_CNT cleared on entry. lock_s=0 goes to PWRDN and increments LOSS_CNT (saturating).
REQ-023 FAULT: PLL_POWERDOWN_N=0, FABRIC_RESET_N=0, FAULT=1. The only exit is RESTART, which goes to PWRDN.
REQ-024 RESTART in any state SHALL go to PWRDN with RETRY_CNT=0. RESTART has priority over timeout, lock loss and the stable-count completion in the same cycle.
REQ-025 All outputs SHALL be registered and SHALL update on the same edge as the state register.
REQ-026 FABRIC_RESET_N SHALL be 0 in every state except RUN.
REQ-027 FABRIC_RESET_N SHALL fall no later than 3 cycles after PLL_LOCK falls.
REQ-028 Parameter values SHALL be 1..2^20; elaboration SHALL fail otherwise.

Reset
REQ-029 While RESETN=0, the block SHALL hold: state=PWRDN, counter=0, synchronizer=0, PLL_POWERDOWN_N=0, FABRIC_RESET_N=0, READY=0, FAULT=0, RETRY_CNT=0, LOSS_CNT=0.
REQ-030 Reset assertion SHALL take effect immediately, including mid-sequence.
REQ-031 Reset release SHALL be synchronous to CLK.

Structure
REQ-032 A shared package SHALL hold the state enumeration/encoding and the counter width constant (20).
REQ-033 The synchronizer SHALL be one sub-module, sync_2ff, reusable for other asynchronous status inputs.

Verification (PD_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-034 Nominal relock:
- Stimulus: PLL_LOCK rises 10 cycles after PLL_POWERDOWN_N rises.
- Required: PLL_POWERDOWN_N rises 4 cycles after RESETN release; READY=1 and FABRIC_RESET_N=1 exactly 2+8 cycles after the lock edge.
REQ-035 No lock:
- Stimulus: PLL_LOCK held 0.
- Required: three PWRDN(4)+WAIT_LOCK(100) attempts, then FAULT=1, PLL_POWERDOWN_N=0, RETRY_CNT=2.
REQ-036 Glitch in STABILIZE:
- Stimulus: PLL_LOCK low for 1 cycle after 5 stable cycles.
- Required: return to WAIT_LOCK with READY=0 throughout; RUN is reached 8 stable cycles after resync; RETRY_CNT unchanged.
REQ-037 Loss in RUN:
- Stimulus: PLL_LOCK falls.
- Required: FABRIC_RESET_N=0 within 3 cycles, LOSS_CNT=1, a full relock follows.
- Repeat 300 losses: LOSS_CNT saturates at 255.
REQ-038 RESTART:
- In FAULT: the FSM goes to PWRDN, FAULT=0, RETRY_CNT=0.
- In RUN, in the same cycle as the synchronized lock loss: the FSM goes to PWRDN and RETRY_CNT=0.
REQ-039 Reset mid-STABILIZE:
- Stimulus: RESETN asserted.
- Required: all outputs take their reset values before the next CLK edge; after release, the sequence restarts at PWRDN.
